// File: rtl/rr_arb_mux.sv
// Round-robin arbiter feeding a single registered output slot with valid/ready handshakes.
// Define RR_ARB_MUX_LOCK_EN to hold the grant on one channel until it sends a beat with in_last set.
module rr_arb_mux #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN-1:0]       in_last,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] outData_q, outData_d;
  logic [SEL_W-1:0] outSel_q, outSel_d;
  logic             outValid_q, outValid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             canLoad;
  logic             grantVld;
  logic [SEL_W-1:0] grantIdx;
  logic             accept;
  logic [WIDTH-1:0] selData;
  logic [SEL_W-1:0] nextPtr;

`ifdef RR_ARB_MUX_LOCK_EN
  logic             locked_q, locked_d;
  logic [SEL_W-1:0] lockCh_q, lockCh_d;
`else
  logic             unusedLast;
  assign unusedLast = ^in_last;
`endif

  assign canLoad = !outValid_q || out_ready;

  // Search upward from ptr with wrap; the first valid channel wins.
  always_comb begin
    int idx;
    grantVld = 1'b0;
    grantIdx = '0;
    idx      = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!grantVld && in_valid[idx]) begin
        grantVld = 1'b1;
        grantIdx = SEL_W'(idx);
      end
    end
`ifdef RR_ARB_MUX_LOCK_EN
    if (locked_q) begin
      grantVld = in_valid[lockCh_q];
      grantIdx = lockCh_q;
    end
`endif
  end

  assign accept  = grantVld && canLoad;
  assign selData = in_data[int'(grantIdx)*WIDTH +: WIDTH];
  assign nextPtr = (grantIdx == SEL_W'(NUM_IN - 1)) ? '0 : grantIdx + SEL_W'(1);

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grantIdx] = 1'b1;
  end

  // A fresh accept overwrites the slot even while it drains, so no bubble appears.
  always_comb begin
    outData_d  = outData_q;
    outSel_d   = outSel_q;
    outValid_d = outValid_q;
    ptr_d      = ptr_q;
`ifdef RR_ARB_MUX_LOCK_EN
    locked_d   = locked_q;
    lockCh_d   = lockCh_q;
`endif
    if (accept) begin
      outData_d  = selData;
      outSel_d   = grantIdx;
      outValid_d = 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
      if (in_last[grantIdx]) begin
        locked_d = 1'b0;
        ptr_d    = nextPtr;
      end else begin
        locked_d = 1'b1;
        lockCh_d = grantIdx;
      end
`else
      ptr_d      = nextPtr;
`endif
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
      outData_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outData_q  <= '0;
      outSel_q   <= '0;
      outValid_q <= 1'b0;
      ptr_q      <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
      locked_q   <= 1'b0;
      lockCh_q   <= '0;
`endif
    end else begin
      outData_q  <= outData_d;
      outSel_q   <= outSel_d;
      outValid_q <= outValid_d;
      ptr_q      <= ptr_d;
`ifdef RR_ARB_MUX_LOCK_EN
      locked_q   <= locked_d;
      lockCh_q   <= lockCh_d;
`endif
    end
  end

  assign out_data  = outData_q;
  assign out_sel   = outSel_q;
  assign out_valid = outValid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Table-driven bench for rr_arb_mux with NUM_IN=3, WIDTH=16; each row is one clock cycle.
// Lock expectations switch with RR_ARB_MUX_LOCK_EN so the bench matches either build.
module tb_rr_arb_mux;

  localparam int WIDTH  = 16;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;

  logic                    clk;
  logic                    rst;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_last;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic [2:0]  valid;
    logic [2:0]  last;
    logic        outReady;
    logic [15:0] d0, d1, d2;
    logic [2:0]  expReady;
    logic        expValid;
    logic [15:0] expData;
    logic [1:0]  expSel;
  } vec_t;

  vec_t vecs[$];

  rr_arb_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(string name, logic r, logic [2:0] v, logic [2:0] l, logic ordy,
                              logic [15:0] d2, logic [2:0] er, logic ev, logic [15:0] ed,
                              logic [1:0] es);
    vec_t t;
    t.name = name; t.rst = r; t.valid = v; t.last = l; t.outReady = ordy;
    t.d0 = 16'h0011; t.d1 = 16'h0022; t.d2 = d2;
    t.expReady = er; t.expValid = ev; t.expData = ed; t.expSel = es;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one row, check the combinational ready before the edge and the registers after it.
  task automatic applyStimulus(input vec_t v);
    rst       = v.rst;
    in_valid  = v.valid;
    in_last   = v.last;
    out_ready = v.outReady;
    in_data   = {v.d2, v.d1, v.d0};
    #2;
    checkOutput({v.name, ".in_ready"}, 32'(in_ready), 32'(v.expReady));
    @(posedge clk);
    #1;
    checkOutput({v.name, ".out_valid"}, 32'(out_valid), 32'(v.expValid));
    checkOutput({v.name, ".out_data"}, 32'(out_data), 32'(v.expData));
    checkOutput({v.name, ".out_sel"}, 32'(out_sel), 32'(v.expSel));
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b0; in_data = '0;

    // Reset then round-robin streaming at full rate.
    vecs.push_back(mk("reset",      1, 3'b000, 3'b111, 1, 16'h0033, 3'b000, 0, 16'h0000, 0));
    vecs.push_back(mk("stream0",    0, 3'b111, 3'b111, 1, 16'h0033, 3'b001, 1, 16'h0011, 0));
    vecs.push_back(mk("stream1",    0, 3'b111, 3'b111, 1, 16'h0033, 3'b010, 1, 16'h0022, 1));
    vecs.push_back(mk("stream2",    0, 3'b111, 3'b111, 1, 16'h0033, 3'b100, 1, 16'h0033, 2));
    vecs.push_back(mk("stream3",    0, 3'b111, 3'b111, 1, 16'h0033, 3'b001, 1, 16'h0011, 0));
    // Back-pressure right after a first load.
    vecs.push_back(mk("bpReset",    1, 3'b000, 3'b111, 1, 16'h0033, 3'b000, 0, 16'h0000, 0));
    vecs.push_back(mk("bpLoad",     0, 3'b111, 3'b111, 0, 16'h0033, 3'b001, 1, 16'h0011, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk("bpHold",   0, 3'b111, 3'b111, 0, 16'h0033, 3'b000, 1, 16'h0011, 0));
    vecs.push_back(mk("bpRelease",  0, 3'b111, 3'b111, 1, 16'h0033, 3'b010, 1, 16'h0022, 1));
    // Single beat from channel 2 drains to empty.
    vecs.push_back(mk("drainBeat",  0, 3'b100, 3'b111, 1, 16'hBEEF, 3'b100, 1, 16'hBEEF, 2));
    vecs.push_back(mk("drainEmpty", 0, 3'b000, 3'b111, 1, 16'hBEEF, 3'b000, 0, 16'h0000, 2));
    vecs.push_back(mk("drainIdle",  0, 3'b000, 3'b111, 1, 16'hBEEF, 3'b000, 0, 16'h0000, 2));
    // Reset while a beat is stalled; ptr was 1 before reset and must restart at 0.
    vecs.push_back(mk("midLoad",    0, 3'b001, 3'b111, 0, 16'h0033, 3'b001, 1, 16'h0011, 0));
    vecs.push_back(mk("midReset",   1, 3'b111, 3'b111, 0, 16'h0033, 3'b000, 0, 16'h0000, 0));
    vecs.push_back(mk("midPtr0",    0, 3'b111, 3'b111, 1, 16'h0033, 3'b001, 1, 16'h0011, 0));
    // Sparse valids exercise skip-ahead and wrap of the search.
    vecs.push_back(mk("skip2",      0, 3'b101, 3'b111, 1, 16'h0033, 3'b100, 1, 16'h0033, 2));
    vecs.push_back(mk("skip1",      0, 3'b110, 3'b111, 1, 16'h0033, 3'b010, 1, 16'h0022, 1));
    vecs.push_back(mk("wrap0",      0, 3'b011, 3'b111, 1, 16'h0033, 3'b001, 1, 16'h0011, 0));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Three-beat packet from channel 0 while the others stay valid.
    applyStimulus(mk("pktReset", 1, 3'b000, 3'b000, 1, 16'h0033, 3'b000, 0, 16'h0000, 0));
    applyStimulus(mk("pktBeat1", 0, 3'b111, 3'b000, 1, 16'h0033, 3'b001, 1, 16'h0011, 0));
`ifdef RR_ARB_MUX_LOCK_EN
    applyStimulus(mk("pktBeat2", 0, 3'b111, 3'b000, 1, 16'h0033, 3'b001, 1, 16'h0011, 0));
    applyStimulus(mk("pktBeat3", 0, 3'b111, 3'b001, 1, 16'h0033, 3'b001, 1, 16'h0011, 0));
    applyStimulus(mk("pktNext",  0, 3'b111, 3'b111, 1, 16'h0033, 3'b010, 1, 16'h0022, 1));
`else
    applyStimulus(mk("pktBeat2", 0, 3'b111, 3'b000, 1, 16'h0033, 3'b010, 1, 16'h0022, 1));
    applyStimulus(mk("pktBeat3", 0, 3'b111, 3'b001, 1, 16'h0033, 3'b100, 1, 16'h0033, 2));
    applyStimulus(mk("pktNext",  0, 3'b111, 3'b111, 1, 16'h0033, 3'b001, 1, 16'h0011, 0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameters SHALL be as follows:
- WIDTH, default 16: data width per channel.
- NUM_IN, default 3: number of input channels, legal range 2..16.
- SEL_W, default $clog2(NUM_IN) (minimum 1): width of out_sel.
REQ-003 Ports SHALL be as follows:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_data  in  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  NUM_IN  per-channel valid
- in_last  in  NUM_IN  per-channel end-of-packet flag
- in_ready  out  NUM_IN  per-channel accept
- out_data  out  WIDTH  registered data
- out_sel  out  SEL_W  index of the source channel of out_data
- out_valid  out  1  output holds a beat
- out_ready  in  1  downstream accept

Function
REQ-004 A beat SHALL transfer on any port when valid and ready are both 1 at a rising clk edge.
REQ-005 The output stage SHALL be a single register slot; can_load = !out_valid || out_ready.
REQ-006 The arbiter SHALL grant the first channel with in_valid=1, searching upward from pointer ptr and wrapping from NUM_IN-1 to 0; grant is combinational.
REQ-007 in_ready[i] SHALL equal grant[i] && can_load; at most one in_ready bit SHALL be 1 in any cycle.
REQ-008 in_ready SHALL NOT depend on in_valid of the granted channel beyond grant selection; in_ready is 0 for every channel when no channel is valid.
REQ-009 On an accept from channel i, the block SHALL load out_data=in_data[i] and out_sel=i, and set out_valid=1 on the next edge; latency is exactly 1 cycle.
REQ-010 On an accept from channel i (lock logic per REQ-017), ptr SHALL become (i+1) mod NUM_IN.
REQ-011 If out_valid && out_ready with no new accept, out_valid SHALL become 0 and out_data SHALL become 0; out_sel SHALL hold its value.
REQ-012 When output drain and input accept occur in the same cycle, the new beat SHALL replace the old one with no bubble, sustaining 1 beat/cycle.
REQ-013 While out_valid && !out_ready, out_data, out_sel and ptr SHALL hold, and all in_ready bits SHALL be 0.
REQ-014 A channel that is valid SHALL be granted within NUM_IN accepts (starvation-free) when the lock feature is off.

Reset
REQ-015 While rst=1 at a clk edge: out_valid=0, out_data=0, out_sel=0, ptr=0, and lock state is cleared.
REQ-016 Reset SHALL take priority over any simultaneous transfer; a beat held in the output slot is discarded and a locked packet is abandoned.

Configuration
REQ-017 With macro RR_ARB_MUX_LOCK_EN defined, packet lock SHALL apply:
- Accepting a beat with in_last[i]=0 locks the grant to channel i and leaves ptr unchanged.
- While locked, grant is channel i only; other channels get in_ready=0 even when valid.
- Accepting a beat from i with in_last[i]=1 releases the lock and sets ptr=(i+1) mod NUM_IN.
REQ-018 Without RR_ARB_MUX_LOCK_EN, in_last SHALL be ignored, no lock state SHALL be synthesised, and every accept SHALL advance ptr per REQ-010.

Verification
REQ-019 The bench SHALL cover the following scenarios with NUM_IN=3, WIDTH=16:
- Reset: release rst, out_ready=1, all inputs valid with values 0x0011, 0x0022, 0x0033 -> outputs 0x0011, 0x0022, 0x0033, 0x0011... on consecutive cycles, with out_sel 0,1,2,0.
- Back-pressure: out_ready=0 for 4 cycles after the first load -> out_data holds 0x0011, in_ready=000 throughout, the next grant is channel 1.
- Drain to empty: only channel 2 valid for one beat (0xBEEF), out_ready=1 -> out_valid pulses 1 cycle, out_sel=2, then out_data=0 and out_valid=0.
- Reset mid-operation: assert rst while out_valid=1 with out_ready=0 -> next cycle out_valid=0, out_data=0, ptr=0.
- Lock on (RR_ARB_MUX_LOCK_EN): channel 0 sends 3 beats (last on the third) while channels 1 and 2 are valid -> out_sel=0,0,0 then 1; in_ready[1]=in_ready[2]=0 during the packet.
- Lock off (same stimulus as the lock-on scenario) -> out_sel=0,1,2,0.
